// File: rtl/dmem_ctrl.sv
// Shares a single-port word memory between the core LSU (byte/half/word) and a
// word-only DMA port; sub-word stores are done as read-modify-write.
module dmem_ctrl #(
  parameter int ADDR_W    = 30,
  parameter int MEM_WORDS = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [31:0]       c_addr,
  input  logic [31:0]       c_wdata,
  input  logic [1:0]        c_size,
  input  logic              c_unsigned,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [31:0]       c_rdata,
  output logic              c_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_w_en,
  output logic              mem_read_en,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MERGE  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  logic [1:0]  state_q, state_d;
  logic        last_d_q, last_d_d;
  logic        own_d_q, own_d_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        err_q, err_d;
  logic [31:0] merged_q, merged_d;
  logic [31:0] rdata_q, rdata_d;

  logic        gnt_c_s, gnt_d_s;
  logic        req_we_s, req_uns_s, req_err_s;
  logic [31:0] req_addr_s, req_wdata_s;
  logic [1:0]  req_size_s;
  logic        resp_s, access_s, merge_s;

  function automatic logic access_err(input logic [31:0] a, input logic [1:0] sz);
    logic misalign;
    case (sz)
      SZ_B:    misalign = 1'b0;
      SZ_H:    misalign = a[0];
      SZ_W:    misalign = (a[1:0] != 2'b00);
      default: misalign = 1'b1;
    endcase
    return misalign || ({2'b00, a[31:2]} >= 32'(MEM_WORDS));
  endfunction

  function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [1:0] off, input logic [1:0] sz);
    logic [31:0] r;
    r = old;
    case (sz)
      SZ_B: begin
        case (off)
          2'd0:    r[7:0]   = wd[7:0];
          2'd1:    r[15:8]  = wd[7:0];
          2'd2:    r[23:16] = wd[7:0];
          default: r[31:24] = wd[7:0];
        endcase
      end
      SZ_H: begin
        if (off[1]) r[31:16] = wd[15:0];
        else        r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [1:0] off,
                                              input logic [1:0] sz, input logic uns);
    logic [31:0] sh;
    logic [31:0] r;
    sh = raw >> {off, 3'b000};
    case (sz)
      SZ_B:    r = {{24{~uns & sh[7]}}, sh[7:0]};
      SZ_H:    r = {{16{~uns & sh[15]}}, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

  // Arbitration: grants only from IDLE; ties go to the port not served last.
  always_comb begin
    gnt_c_s = 1'b0;
    gnt_d_s = 1'b0;
    if (!rst && (state_q == S_IDLE)) begin
      if (c_req && d_req) begin
        if (last_d_q) gnt_c_s = 1'b1;
        else          gnt_d_s = 1'b1;
      end else if (c_req) begin
        gnt_c_s = 1'b1;
      end else if (d_req) begin
        gnt_d_s = 1'b1;
      end else begin
        gnt_c_s = 1'b0;
      end
    end else begin
      gnt_c_s = 1'b0;
    end
  end

  assign req_we_s    = gnt_d_s ? d_we    : c_we;
  assign req_addr_s  = gnt_d_s ? d_addr  : c_addr;
  assign req_wdata_s = gnt_d_s ? d_wdata : c_wdata;
  assign req_size_s  = gnt_d_s ? SZ_W    : c_size;
  assign req_uns_s   = gnt_d_s ? 1'b0    : c_unsigned;
  assign req_err_s   = access_err(req_addr_s, req_size_s);

  // Transaction sequencing and request capture.
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    own_d_d  = own_d_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    uns_d    = uns_q;
    err_d    = err_q;
    merged_d = merged_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_c_s || gnt_d_s) begin
          last_d_d = gnt_d_s;
          own_d_d  = gnt_d_s;
          we_d     = req_we_s;
          addr_d   = req_addr_s;
          wdata_d  = req_wdata_s;
          size_d   = req_size_s;
          uns_d    = req_uns_s;
          err_d    = req_err_s;
          rdata_d  = 32'd0;
          if (req_err_s)                            state_d = S_RESP;
          else if (req_we_s && (req_size_s != SZ_W)) state_d = S_MERGE;
          else                                      state_d = S_ACCESS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MERGE: begin
        merged_d = merge_word(mem_rdata, wdata_q, addr_q[1:0], size_q);
        state_d  = S_ACCESS;
      end
      S_ACCESS: begin
        if (!we_q) rdata_d = load_extend(mem_rdata, addr_q[1:0], size_q, uns_q);
        else       rdata_d = 32'd0;
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and captured-request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      last_d_q <= 1'b1;
      own_d_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      size_q   <= SZ_W;
      uns_q    <= 1'b0;
      err_q    <= 1'b0;
      merged_q <= 32'd0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      own_d_q  <= own_d_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      err_q    <= err_d;
      merged_q <= merged_d;
      rdata_q  <= rdata_d;
    end
  end

  assign resp_s   = (state_q == S_RESP);
  assign access_s = (state_q == S_ACCESS);
  assign merge_s  = (state_q == S_MERGE);

  assign c_gnt    = gnt_c_s;
  assign d_gnt    = gnt_d_s;
  assign c_rvalid = resp_s && !own_d_q;
  assign d_rvalid = resp_s && own_d_q;
  assign c_err    = c_rvalid && err_q;
  assign d_err    = d_rvalid && err_q;
  assign c_rdata  = c_rvalid ? rdata_q : 32'd0;
  assign d_rdata  = d_rvalid ? rdata_q : 32'd0;

  // The memory writes on the falling edge, so a reset raised mid-ACCESS must kill the strobe now.
  assign mem_addr    = (merge_s || access_s) ? addr_q[ADDR_W+1:2] : {ADDR_W{1'b0}};
  assign mem_read_en = merge_s || (access_s && !we_q);
  assign mem_w_en    = access_s && we_q && !rst;
  assign mem_wdata   = (access_s && we_q) ? ((size_q == SZ_W) ? wdata_q : merged_q) : 32'd0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: grants push transactions, a response monitor
// pops them and checks against a word-array reference model.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, c_unsigned, c_gnt, c_rvalid, c_err;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic [1:0]  c_size;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_w_en, mem_read_en;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_W(30), .MEM_WORDS(512)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_size(c_size),
    .c_unsigned(c_unsigned), .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_w_en(mem_w_en),
    .mem_read_en(mem_read_en), .mem_rdata(mem_rdata)
  );

  logic [31:0] mem [0:511];
  logic [31:0] ref_mem [0:511];
  assign mem_rdata = mem[mem_addr[8:0]];
  always @(negedge clk) if (mem_w_en) mem[mem_addr[8:0]] <= mem_wdata;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    bit          uns;
    int          t0;
  } txn_t;

  txn_t        sb[$];
  bit          grant_log[$];
  int          tests = 0, fails = 0, cyc = 0, n_wen = 0, n_ren = 0;
  bit          model_last_d = 1'b1;
  logic [31:0] last_rdata;
  bit          last_err;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: outcome of one transaction against the word array ref_mem.
  function automatic void model(input txn_t t, output bit err, output logic [31:0] rd,
                                output int lat, output logic [31:0] nw);
    int          sh;
    int          v;
    logic [31:0] old;
    sh  = int'(t.addr % 4) * 8;
    err = (t.size == 2'd3) || (t.size == 2'd1 && t.addr % 2 != 0) ||
          (t.size == 2'd2 && t.addr % 4 != 0) || (t.addr / 4 >= 512);
    lat = err ? 1 : ((t.we && t.size != 2'd2) ? 3 : 2);
    rd  = 32'd0;
    nw  = 32'd0;
    if (!err) begin
      old = ref_mem[int'(t.addr / 4)];
      if (t.we) begin
        if (t.size == 2'd0)      nw = (old & ~(32'hFF << sh)) | ((t.wdata & 32'hFF) << sh);
        else if (t.size == 2'd1) nw = (old & ~(32'hFFFF << sh)) | ((t.wdata & 32'hFFFF) << sh);
        else                     nw = t.wdata;
      end else begin
        if (t.size == 2'd0) begin
          v = int'((old >> sh) & 32'hFF);
          if (!t.uns && v >= 128) v = v - 256;
        end else if (t.size == 2'd1) begin
          v = int'((old >> sh) & 32'hFFFF);
          if (!t.uns && v >= 32768) v = v - 65536;
        end else begin
          v = int'(old);
        end
        rd = 32'(v);
      end
    end
  endfunction

  // Bus monitor: arbitration checks, scoreboard push on grant, strobe accounting.
  initial forever begin
    txn_t t;
    @(negedge clk);
    if (rst) model_last_d = 1'b1;
    if (mem_w_en) n_wen++;
    if (mem_read_en) n_ren++;
    if ((mem_w_en || mem_read_en) && sb.size() > 0) chk("mem_addr", {2'b00, mem_addr}, sb[0].addr >> 2);
    if (mem_w_en && sb.size() > 0 && sb[0].size == 2'd2) chk("mem_wdata", mem_wdata, sb[0].wdata);
    if (c_gnt || d_gnt) begin
      chk("gnt_onehot", {31'd0, c_gnt & d_gnt}, 32'd0);
      chk("gnt_outstanding", sb.size(), 32'd0);
      chk("gnt_has_req", {31'd0, d_gnt ? d_req : c_req}, 32'd1);
      if (c_req && d_req) chk("rr_tie", {31'd0, d_gnt}, {31'd0, ~model_last_d});
      model_last_d = d_gnt;
      t.is_d  = d_gnt;
      t.we    = d_gnt ? d_we : c_we;
      t.addr  = d_gnt ? d_addr : c_addr;
      t.wdata = d_gnt ? d_wdata : c_wdata;
      t.size  = d_gnt ? 2'd2 : c_size;
      t.uns   = d_gnt ? 1'b0 : c_unsigned;
      t.t0    = cyc;
      sb.push_back(t);
      grant_log.push_back(d_gnt);
      n_wen = 0;
      n_ren = 0;
    end
  end

  // Response monitor: pops the scoreboard on every completion pulse.
  initial forever begin
    txn_t        t;
    bit          e;
    logic [31:0] rd, nw;
    int          lat;
    @(negedge clk);
    if (c_rvalid || d_rvalid) begin
      chk("rvalid_onehot", {31'd0, c_rvalid & d_rvalid}, 32'd0);
      if (sb.size() == 0) begin
        chk("rvalid_unexpected", sb.size(), 32'd1);
      end else begin
        t = sb.pop_front();
        model(t, e, rd, lat, nw);
        last_rdata = d_rvalid ? d_rdata : c_rdata;
        last_err   = d_rvalid ? d_err : c_err;
        chk("resp_port", {31'd0, d_rvalid}, {31'd0, t.is_d});
        chk("latency", cyc - t.t0, lat);
        chk("err", {31'd0, last_err}, {31'd0, e});
        chk("rdata", last_rdata, rd);
        chk("w_en_count", n_wen, (!e && t.we) ? 1 : 0);
        chk("read_en_count", n_ren, e ? 0 : ((!t.we || t.size != 2'd2) ? 1 : 0));
        if (t.we && !e) begin
          ref_mem[int'(t.addr / 4)] = nw;
          chk("mem_word", mem[int'(t.addr / 4)], nw);
        end
      end
    end
  end

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("drain", sb.size(), 32'd0);
  endtask

  task automatic txn(input bit pd, input bit we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [1:0] sz, input bit u);
    int k = 0;
    @(posedge clk); #1;
    if (pd) begin
      d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
    end else begin
      c_we = we; c_addr = a; c_wdata = wd; c_size = sz; c_unsigned = u; c_req = 1'b1;
    end
    do begin
      @(negedge clk);
      k++;
    end while (!(pd ? d_gnt : c_gnt) && k < 20);
    chk("gnt_seen", {31'd0, pd ? d_gnt : c_gnt}, 32'd1);
    @(posedge clk); #1;
    c_req = 1'b0;
    d_req = 1'b0;
    drain();
  endtask

  task automatic c_stream();
    for (int i = 0; i < 4; i++) begin
      int k = 0;
      c_we = (i % 2 == 0); c_addr = 32'h40; c_wdata = 32'hC0DE0000 + i;
      c_size = 2'd2; c_unsigned = 1'b0; c_req = 1'b1;
      do begin @(negedge clk); k++; end while (!c_gnt && k < 40);
      chk("c_stream_gnt", {31'd0, c_gnt}, 32'd1);
      @(posedge clk); #1;
    end
    c_req = 1'b0;
  endtask

  task automatic d_stream(input logic [31:0] val);
    for (int i = 0; i < 4; i++) begin
      int k = 0;
      d_we = (i % 2 == 0); d_addr = 32'h80; d_wdata = val + i; d_req = 1'b1;
      do begin @(negedge clk); k++; end while (!d_gnt && k < 40);
      chk("d_stream_gnt", {31'd0, d_gnt}, 32'd1);
      @(posedge clk); #1;
    end
    d_req = 1'b0;
  endtask

  initial begin
    int nbad;
    for (int i = 0; i < 512; i++) begin
      mem[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    rst = 1'b1;
    c_req = 1'b0; c_we = 1'b0; c_addr = 32'd0; c_wdata = 32'd0; c_size = 2'd2; c_unsigned = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt_rvalid", {28'd0, c_gnt, d_gnt, c_rvalid, d_rvalid}, 32'd0);
    chk("rst_err_strobe", {28'd0, c_err, d_err, mem_w_en, mem_read_en}, 32'd0);
    chk("rst_c_rdata", c_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_mem_addr", {2'b00, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0);
    txn(1'b0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    chk("lw_deadbeef", last_rdata, 32'hDEADBEEF);

    txn(1'b0, 1'b1, 32'h10, 32'h11223344, 2'd2, 1'b0);
    txn(1'b0, 1'b1, 32'h12, 32'h000000AB, 2'd0, 1'b0);
    chk("sb_rmw", mem[4], 32'h11AB3344);

    txn(1'b0, 1'b1, 32'h10, 32'h80FF7F01, 2'd2, 1'b0);
    txn(1'b0, 1'b0, 32'h13, 32'h0, 2'd0, 1'b0);
    chk("lb_0x13", last_rdata, 32'hFFFFFF80);
    txn(1'b0, 1'b0, 32'h13, 32'h0, 2'd0, 1'b1);
    chk("lbu_0x13", last_rdata, 32'h00000080);
    txn(1'b0, 1'b0, 32'h10, 32'h0, 2'd1, 1'b0);
    chk("lh_0x10", last_rdata, 32'h00007F01);
    txn(1'b0, 1'b0, 32'h12, 32'h0, 2'd1, 1'b0);
    chk("lh_0x12", last_rdata, 32'hFFFF80FF);

    txn(1'b0, 1'b0, 32'h6, 32'h0, 2'd2, 1'b0);
    chk("err_lw_0x6", {31'd0, last_err}, 32'd1);
    txn(1'b0, 1'b0, 32'h11, 32'h0, 2'd1, 1'b0);
    chk("err_lh_0x11", {31'd0, last_err}, 32'd1);
    txn(1'b1, 1'b1, 32'h800, 32'h55AA55AA, 2'd2, 1'b0);
    chk("err_d_sw_0x800", {31'd0, last_err}, 32'd1);
    txn(1'b0, 1'b0, 32'h10, 32'h0, 2'd3, 1'b0);
    chk("err_size3", {31'd0, last_err}, 32'd1);

    // Reset during ACCESS of c sw 0x20.
    @(posedge clk); #1;
    c_we = 1'b1; c_addr = 32'h20; c_wdata = 32'h12345678; c_size = 2'd2; c_req = 1'b1;
    @(negedge clk);
    chk("rmo_gnt", {31'd0, c_gnt}, 32'd1);
    @(posedge clk); #1;
    c_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rmo_wen_suppressed", {31'd0, mem_w_en}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    c_we = 1'b0; c_addr = 32'h20; c_req = 1'b1;
    d_we = 1'b0; d_addr = 32'h24; d_req = 1'b1;
    @(negedge clk);
    chk("rmo_no_rvalid", {31'd0, c_rvalid}, 32'd0);
    chk("rmo_mem8", mem[8], ref_mem[8]);
    chk("rmo_tie_c", {30'd0, c_gnt, d_gnt}, 32'd2);
    @(posedge clk); #1;
    c_req = 1'b0;
    drain();
    txn(1'b1, 1'b0, 32'h24, 32'h0, 2'd2, 1'b0);

    // Round-robin with both requests held from reset.
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    grant_log.delete();
    fork
      c_stream();
      d_stream(32'hD00D0000);
      begin repeat (2) @(posedge clk); #1 rst = 1'b0; end
    join
    drain();
    chk("rr_count", grant_log.size(), 32'd8);
    for (int i = 0; i < grant_log.size(); i++) chk("rr_order", {31'd0, grant_log[i]}, i % 2);
    chk("rr_d_readback", last_rdata, 32'hD00D0002);

    for (int n = 0; n < 150; n++) begin
      bit          pd, we, u;
      logic [1:0]  sz;
      logic [31:0] a;
      int          r;
      pd = ($urandom_range(0, 3) == 0);
      we = $urandom_range(0, 1);
      u  = $urandom_range(0, 1);
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      a  = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(500, 530)) : 32'($urandom_range(0, 15));
      a  = (a << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) a = a & ((sz == 2'd1) ? 32'hFFFFFFFE : (sz == 2'd0) ? 32'hFFFFFFFF : 32'hFFFFFFFC);
      txn(pd, we, a, $urandom, sz, u);
    end

    nbad = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) nbad++;
    chk("mem_final", nbad, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Memory-side controller that shares the single-port word-addressed data memory between two requesters: the core load/store unit (port c, byte/half/word) and a debug/DMA port (port d, word only). It converts byte addresses to word addresses and sign/zero-extends sub-word loads. Sub-word stores are done as read-modify-write, because the memory writes whole words only. It sits between the execute/writeback stage and the data memory and owns that memory's w_en/read_en/addr/data_in.

Parameters:
ADDR_W, 30, word-address width driven to memory
MEM_WORDS, 512, number of implemented words; word index >= MEM_WORDS is out of range

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
c_req  in  1  core request, held until c_gnt
c_we  in  1  core store (1) / load (0)
c_addr  in  32  core byte address
c_wdata  in  32  core store data, right-aligned
c_size  in  2  00 byte, 01 half, 10 word, 11 illegal
c_unsigned  in  1  zero-extend sub-word load
c_gnt  out  1  core request accepted this cycle
c_rvalid  out  1  core completion pulse
c_rdata  out  32  core load data, valid with c_rvalid
c_err  out  1  core access error, valid with c_rvalid
d_req  in  1  DMA request, held until d_gnt
d_we  in  1  DMA store / load
d_addr  in  32  DMA byte address
d_wdata  in  32  DMA store word
d_gnt  out  1  DMA accepted
d_rvalid  out  1  DMA completion pulse
d_rdata  out  32  DMA load word
d_err  out  1  DMA error
mem_addr  out  ADDR_W  word address to memory
mem_wdata  out  32  write word to memory
mem_w_en  out  1  memory write enable
mem_read_en  out  1  memory read enable
mem_rdata  in  32  asynchronous read data from memory

Behaviour:
- FSM states: IDLE, MERGE, ACCESS, RESP. All outputs are decoded from registered state and registered request fields. The only exception is gnt, which is combinational in IDLE.
- Reset: state=IDLE, last_grant=d (so the core wins the first tie). gnt, rvalid, err, mem_w_en and mem_read_en are 0. rdata is 0. mem_addr and mem_wdata are 0.
- mem_w_en is gated combinationally by ~rst. Asserting rst during ACCESS suppresses the write in that cycle, because the memory writes on the falling edge.
- Reset during an in-flight transaction abandons it: no rvalid, no memory write.
- IDLE arbitration:
  - If exactly one requester has req=1, it gets gnt.
  - If both have req=1, grant goes to the port != last_grant.
  - last_grant updates on every grant.
  - gnt is high for exactly one cycle per transaction.
- On the gnt edge, latch owner, we, addr, wdata, size and unsigned. DMA size is forced to word.
- Error check at the gnt edge:
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - size 11
  - addr[31:2] >= MEM_WORDS
- Next state after the gnt edge:
  - error: RESP with err=1. No memory strobe is ever asserted.
  - load or word store: ACCESS.
  - sub-word store: MERGE.
- MERGE:
  - mem_read_en=1, mem_addr=addr[31:2].
  - Register merged = mem_rdata with the lanes selected by addr[1:0]/size replaced by wdata[7:0] or wdata[15:0].
  - Next state: ACCESS.
- ACCESS:
  - mem_addr=addr[31:2].
  - Store: mem_w_en=1, mem_wdata = merged for sub-word or wdata for word.
  - Load: mem_read_en=1. Register rdata from mem_rdata shifted by addr[1:0]×8 and extended per size/unsigned.
  - Next state: RESP.
- RESP:
  - Owner's rvalid=1 for one cycle, with err. rdata is 0 for stores and errors.
  - Next state: IDLE. No new gnt is issued in RESP; requests are accepted again from IDLE.
- Latency from the gnt cycle T0 to rvalid:
  - load or word store: T2
  - sub-word store: T3
  - error: T1
- Throughput: one transaction per 3 cycles (4 for sub-word store).
- The non-owner port sees no rvalid.
- A requester whose req is deasserted before gnt is not served; req is sampled only in IDLE.

Test Plan:
- Word store then load: c store addr 0x10, data 0xDEADBEEF. mem_w_en for 1 cycle at T1 with mem_addr=4, c_rvalid at T2. Then c load addr 0x10 → c_rdata=0xDEADBEEF at T2, c_err=0.
- Byte store RMW: mem[4]=0x11223344, c sb addr 0x12, data 0xAB. MERGE reads, ACCESS writes 0x11AB3344, c_rvalid at T3.
- Sub-word load extension: mem[4]=0x80FF7F01.
  - lb at 0x13 → 0xFFFFFF80
  - lbu at 0x13 → 0x00000080
  - lh at 0x10 → 0x00007F01
  - lh at 0x12 → 0xFFFF80FF
- Errors, each gives err=1 at T1 and mem_w_en/mem_read_en are never asserted:
  - c lw at 0x6
  - c lh at 0x11
  - d sw at 0x800 (word 512)
  - c size=11
- Round-robin: c_req and d_req held high continuously from reset → grants alternate c, d, c, d. Each rvalid goes only to the owner. d_rdata equals what d last stored.
- Reset mid-op: assert rst during ACCESS of c sw 0x20, data 0x12345678 → mem_w_en=0 that cycle, mem[8] unchanged, no c_rvalid, state IDLE next cycle, next tie grants c.
